// File: rtl/bcd_to_binary_seq_pkg.sv
// bcd_to_binary_seq_pkg: FSM states and BCD digit constants shared by the converter
package bcd_to_binary_seq_pkg;
    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_SUB    = 4'd3;
endpackage

// File: rtl/bcd_to_binary_seq_digit_adjust.sv
// bcd_to_binary_seq_digit_adjust: reverse double-dabble digit correction plus invalid-digit flag
module bcd_to_binary_seq_digit_adjust
    import bcd_to_binary_seq_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit,
    output logic       o_invalid
);
    assign o_digit   = (i_digit >= ADJ_THRESH) ? i_digit - ADJ_SUB : i_digit;
    assign o_invalid = i_digit > BCD_MAX;
endmodule

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: iterative packed-BCD to binary converter, one shift per clock
module bcd_to_binary_seq
    import bcd_to_binary_seq_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcdIn,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [BIN_W-1:0]      binOut
);
    localparam int SR_W  = 4*DIGITS + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    state_t             r_state;
    logic [SR_W-1:0]    r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic [SR_W-1:0]    w_shift;
    logic [SR_W-1:0]    w_next;
    logic [DIGITS-1:0]  w_bad;
    logic               w_last;

    assign w_shift              = r_sr >> 1;
    assign w_next[BIN_W-1:0]    = w_shift[BIN_W-1:0];
    assign w_last               = r_cnt == CNT_W'(BIN_W - 1);

    // In IDLE the digit units validate the incoming BCD; in CONVERT they correct the shifted digits.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        logic [3:0] w_in;
        logic [3:0] w_adj;
        assign w_in = (r_state == S_IDLE) ? bcdIn[4*g +: 4] : w_shift[BIN_W + 4*g +: 4];
        bcd_to_binary_seq_digit_adjust u_adj (
            .i_digit   (w_in),
            .o_digit   (w_adj),
            .o_invalid (w_bad[g])
        );
        assign w_next[BIN_W + 4*g +: 4] = w_adj;
    end

    // Handshake FSM, shift register, counter and registered outputs.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            binOut  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && |w_bad) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        error   <= 1'b1;
                        binOut  <= '0;
                    end else if (start) begin
                        r_state <= S_CONVERT;
                        r_sr    <= {bcdIn, {BIN_W{1'b0}}};
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        error   <= 1'b0;
                    end
                end
                S_CONVERT: begin
                    r_sr  <= w_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        binOut  <= w_next[BIN_W-1:0];
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: directed vectors for 2-digit and 3-digit converters
module tb_bcd_to_binary_seq;
    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        start_a = 1'b0;
    logic [7:0]  bcd_a = '0;
    logic        busy_a, done_a, error_a;
    logic [6:0]  bin_a;
    logic        start_b = 1'b0;
    logic [11:0] bcd_b = '0;
    logic        busy_b, done_b, error_b;
    logic [9:0]  bin_b;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clock = ~clock;

    bcd_to_binary_seq #(.DIGITS(2), .BIN_W(7)) u_a (
        .clock(clock), .resetN(resetN), .start(start_a), .bcdIn(bcd_a),
        .busy(busy_a), .done(done_a), .error(error_a), .binOut(bin_a)
    );

    bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) u_b (
        .clock(clock), .resetN(resetN), .start(start_b), .bcdIn(bcd_b),
        .busy(busy_b), .done(done_b), .error(error_b), .binOut(bin_b)
    );

    typedef struct {
        logic [7:0] bcd;
        int         exp_bin;
        int         exp_err;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One full transaction on the 2-digit unit; bcdIn is scrambled after acceptance.
    task automatic run_a(input logic [7:0] bcd, input int exp_bin, input int exp_err);
        int n;
        @(negedge clock);
        start_a = 1'b1;
        bcd_a = bcd;
        @(negedge clock);
        start_a = 1'b0;
        bcd_a = 8'hFF;
        n = 1;
        if (exp_err == 0) check("a_busy", int'(busy_a), 1);
        while (!done_a && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("a_latency", n, (exp_err != 0) ? 1 : 8);
        check("a_bin", int'(bin_a), exp_bin);
        check("a_err", int'(error_a), exp_err);
        @(negedge clock);
        check("a_done_width", int'(done_a), 0);
        check("a_bin_hold", int'(bin_a), exp_bin);
    endtask

    task automatic run_b(input logic [11:0] bcd, input int exp_bin, input int exp_err);
        int n;
        @(negedge clock);
        start_b = 1'b1;
        bcd_b = bcd;
        @(negedge clock);
        start_b = 1'b0;
        bcd_b = 12'h000;
        n = 1;
        while (!done_b && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("b_latency", n, (exp_err != 0) ? 1 : 11);
        check("b_bin", int'(bin_b), exp_bin);
        check("b_err", int'(error_b), exp_err);
    endtask

    initial begin
        vec_t vecs[12];
        int n;
        int dones;
        vecs[0]  = '{8'h99, 99, 0};
        vecs[1]  = '{8'h00, 0, 0};
        vecs[2]  = '{8'h42, 42, 0};
        vecs[3]  = '{8'h57, 57, 0};
        vecs[4]  = '{8'h1A, 0, 1};
        vecs[5]  = '{8'h10, 10, 0};
        vecs[6]  = '{8'h09, 9, 0};
        vecs[7]  = '{8'h90, 90, 0};
        vecs[8]  = '{8'hA0, 0, 1};
        vecs[9]  = '{8'h81, 81, 0};
        vecs[10] = '{8'h0F, 0, 1};
        vecs[11] = '{8'h88, 88, 0};

        repeat (3) @(negedge clock);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_err", int'(error_a), 0);
        check("rst_bin", int'(bin_a), 0);
        check("rst_b_bin", int'(bin_b), 0);
        resetN = 1'b1;

        for (int i = 0; i < 12; i++) run_a(vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err);

        // start pulsed mid-conversion must be ignored
        @(negedge clock);
        start_a = 1'b1;
        bcd_a = 8'h35;
        @(negedge clock);
        start_a = 1'b0;
        n = 1;
        repeat (2) begin
            @(negedge clock);
            n++;
        end
        start_a = 1'b1;
        bcd_a = 8'h77;
        @(negedge clock);
        n++;
        start_a = 1'b0;
        while (!done_a && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("ign_latency", n, 8);
        check("ign_bin", int'(bin_a), 35);
        dones = 0;
        repeat (12) begin
            @(negedge clock);
            dones += int'(done_a);
        end
        check("ign_no_second_done", dones, 0);
        check("ign_bin_hold", int'(bin_a), 35);

        // reset mid-conversion aborts immediately
        @(negedge clock);
        start_a = 1'b1;
        bcd_a = 8'h88;
        @(negedge clock);
        start_a = 1'b0;
        repeat (3) @(negedge clock);
        resetN = 1'b0;
        #1;
        check("abort_busy", int'(busy_a), 0);
        check("abort_done", int'(done_a), 0);
        check("abort_err", int'(error_a), 0);
        check("abort_bin", int'(bin_a), 0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clock);
            dones += int'(done_a) + int'(busy_a);
        end
        check("abort_quiet", dones, 0);
        run_a(8'h63, 63, 0);

        // start held high: one conversion every BIN_W+2 cycles
        @(negedge clock);
        start_a = 1'b1;
        bcd_a = 8'h21;
        n = 0;
        while (!done_a && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("held_first_done", int'(done_a), 1);
        n = 0;
        @(negedge clock);
        n++;
        while (!done_a && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("held_period", n, 9);
        check("held_bin", int'(bin_a), 21);
        start_a = 1'b0;
        repeat (12) @(negedge clock);

        // 3-digit unit: max value, invalid digit, then every valid input
        run_b(12'h999, 999, 0);
        run_b(12'h9A9, 0, 1);
        for (int v = 0; v < 1000; v++)
            run_b({4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)}, v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
